// File: rtl/bp_pht.sv
// Pattern history table: DEPTH saturating CNT_WIDTH-bit counters, one predict and one train port per cycle.
// Optional macro BP_PHT_BYPASS_EN forwards a same-cycle, same-index update result to the read response.
module bp_pht #(
   parameter int          CNT_WIDTH = 2,
   parameter int          IDX_WIDTH = 6,
   parameter int          DEPTH     = 64,
   parameter int unsigned INIT_CNT  = 2**(CNT_WIDTH-1)
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 busy,
   output logic                 state_dbg,
   input  logic                 rd_valid,
   input  logic [IDX_WIDTH-1:0] rd_idx,
   output logic                 rd_resp_valid,
   output logic                 rd_taken,
   output logic [CNT_WIDTH-1:0] rd_cnt,
   input  logic                 upd_valid,
   input  logic [IDX_WIDTH-1:0] upd_idx,
   input  logic                 upd_taken,
   output logic                 upd_changed
);

   // Handshake: requests have no ready; they are accepted on every edge while busy is low
   // and are dropped (not queued) while busy is high or reset is asserted.

   typedef enum logic {SWEEP = 1'b0, READY = 1'b1} state_t;

   localparam logic [CNT_WIDTH-1:0] INIT_VAL = INIT_CNT[CNT_WIDTH-1:0];
   localparam logic [CNT_WIDTH-1:0] MAX_VAL  = {CNT_WIDTH{1'b1}};
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DEPTH - 1);

   state_t                 state, state_next;
   logic [IDX_WIDTH-1:0]   sweep_ptr, sweep_ptr_next;
   logic [CNT_WIDTH-1:0]   mem [DEPTH];
   logic [CNT_WIDTH-1:0]   upd_cur, upd_next, rd_val;
   logic                   rd_fire, upd_fire;

   assign busy      = (state == SWEEP);
   assign state_dbg = state;
   assign rd_fire   = rd_valid  && (state == READY);
   assign upd_fire  = upd_valid && (state == READY);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SWEEP;
         sweep_ptr <= '0;
      end else begin
         state     <= state_next;
         sweep_ptr <= sweep_ptr_next;
      end
   end

   always_comb begin
      state_next     = state;
      sweep_ptr_next = sweep_ptr;
      if (state == SWEEP) begin
         sweep_ptr_next = sweep_ptr + 1'b1;
         if (sweep_ptr == LAST_IDX) state_next = READY;
      end
   end

   // Saturating read-modify-write of the trained counter.
   always_comb begin
      upd_cur  = mem[upd_idx];
      upd_next = upd_cur;
      if (upd_taken && (upd_cur != MAX_VAL))      upd_next = upd_cur + 1'b1;
      else if (!upd_taken && (upd_cur != '0))     upd_next = upd_cur - 1'b1;
   end

   always_comb begin
`ifdef BP_PHT_BYPASS_EN
      if (upd_fire && (upd_idx == rd_idx)) rd_val = upd_next;
      else                                 rd_val = mem[rd_idx];
`else
      rd_val = mem[rd_idx];
`endif
   end

   // Table storage has no reset; the sweep initialises it.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == SWEEP)  mem[sweep_ptr] <= INIT_VAL;
         else if (upd_valid)  mem[upd_idx]   <= upd_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_resp_valid <= 1'b0;
         rd_taken      <= 1'b0;
         rd_cnt        <= '0;
         upd_changed   <= 1'b0;
      end else begin
         rd_resp_valid <= rd_fire;
         if (rd_fire) begin
            rd_cnt   <= rd_val;
            rd_taken <= rd_val[CNT_WIDTH-1];
         end
         upd_changed <= upd_fire && (upd_next != upd_cur);
      end
   end

endmodule

// File: tb/tb_bp_pht.sv
// Directed bench for bp_pht with CNT_WIDTH=2, DEPTH=16: sweep, saturation, collision, gating, mid-run reset.
module tb_bp_pht;

   localparam int CW = 2;
   localparam int IW = 4;
   localparam int DP = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          busy, state_dbg;
   logic          rd_valid;
   logic [IW-1:0] rd_idx;
   logic          rd_resp_valid, rd_taken;
   logic [CW-1:0] rd_cnt;
   logic          upd_valid;
   logic [IW-1:0] upd_idx;
   logic          upd_taken;
   logic          upd_changed;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   bp_pht #(.CNT_WIDTH(CW), .IDX_WIDTH(IW), .DEPTH(DP)) dut (
      .clk(clk), .reset(reset), .busy(busy), .state_dbg(state_dbg),
      .rd_valid(rd_valid), .rd_idx(rd_idx), .rd_resp_valid(rd_resp_valid),
      .rd_taken(rd_taken), .rd_cnt(rd_cnt),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
      .upd_changed(upd_changed)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int idx, input int exp_cnt, input string tag);
      rd_valid = 1'b1; rd_idx = IW'(idx);
      step();
      rd_valid = 1'b0;
      check({tag, "_vld"},   rd_resp_valid, 1);
      check({tag, "_cnt"},   rd_cnt, exp_cnt);
      check({tag, "_taken"}, rd_taken, (exp_cnt >> (CW-1)) & 1);
   endtask

   task automatic upd(input int idx, input bit taken, input int exp_chg, input string tag);
      upd_valid = 1'b1; upd_idx = IW'(idx); upd_taken = taken;
      step();
      upd_valid = 1'b0;
      check({tag, "_chg"}, upd_changed, exp_chg);
   endtask

   // Counts busy cycles starting just after the reset edge; also checks gating.
   task automatic sweep_wait(input string tag, output int n);
      n = 0;
      while (busy && n < 100) begin
         check({tag, "_chg0"}, upd_changed, 0);
         check({tag, "_rv0"}, rd_resp_valid, 0);
         step();
         n++;
      end
      rd_valid = 1'b0; upd_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; rd_valid = 1'b0; rd_idx = '0;
      upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;
      step();
      reset = 1'b0;
      check("rst_busy", busy, 1);
      check("rst_state", state_dbg, 0);
      check("rst_rv", rd_resp_valid, 0);
      check("rst_cnt", rd_cnt, 0);
      check("rst_taken", rd_taken, 0);
      check("rst_chg", upd_changed, 0);

      // Requests during the sweep must be ignored.
      upd_valid = 1'b1; upd_idx = 4'd0; upd_taken = 1'b0;
      rd_valid = 1'b1; rd_idx = 4'd0;
      sweep_wait("sweep", n);
      check("sweep_len", n, 16);
      check("ready_state", state_dbg, 1);

      for (int i = 0; i < DP; i++) rd(i, 2, $sformatf("init%0d", i));
      step();
      check("idle_rv", rd_resp_valid, 0);
      check("idle_hold", rd_cnt, 2);

      for (int k = 0; k < 4; k++) begin
         upd(5, 1'b1, (k == 0) ? 1 : 0, $sformatf("satup%0d", k));
         rd(5, 3, $sformatf("satup_rd%0d", k));
      end

      upd(7, 1'b0, 1, "satdn0");
      upd(7, 1'b0, 1, "satdn1");
      upd(7, 1'b0, 0, "satdn2");
      rd(7, 0, "satdn_rd");

      // Same-index collision on idx 3 (currently 2).
      upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b0;
`ifdef BP_PHT_BYPASS_EN
      rd(3, 1, "coll");
`else
      rd(3, 2, "coll");
`endif
      upd_valid = 1'b0;
      check("coll_chg", upd_changed, 1);
      rd(3, 1, "coll_after");

      // Different indices in one cycle are independent.
      upd_valid = 1'b1; upd_idx = 4'd2; upd_taken = 1'b1;
      rd(5, 3, "indep");
      upd_valid = 1'b0;
      check("indep_chg", upd_changed, 1);
      rd(2, 3, "indep_after");

      upd(9, 1'b1, 1, "tr9");
      rd(9, 3, "tr9_rd");

      // Reset mid-operation with an update presented in the reset cycle.
      reset = 1'b1; upd_valid = 1'b1; upd_idx = 4'd9; upd_taken = 1'b0;
      step();
      reset = 1'b0; upd_valid = 1'b0;
      check("rst2_busy", busy, 1);
      check("rst2_cnt", rd_cnt, 0);
      sweep_wait("sweep2", n);
      check("sweep2_len", n, 16);
      rd(9, 2, "rst2_rd9");
      rd(5, 2, "rst2_rd5");
      rd(7, 2, "rst2_rd7");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
